rr_arbiter_4: RTL

//   Round-robin arbiter that shares one resource among 4 requesters. It rotates

---
 rtl/rr_arbiter_4.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with registered one-hot grant and hold-time preemption
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EIN,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       EOUT
);

  typedef enum logic {IDLE, BUSY} state_t;

  // MAX_HOLD of 0 means unlimited hold; the counter then just saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] cand;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;
  logic       take;

  // While busy the owner is masked out, so it naturally lands last in rotation.
  always_comb begin
    cand  = (state_q == BUSY) ? (req & ~gnt_q) : req;
    idx   = 2'd0;
    win   = 2'd0;
    found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    if (!EIN) begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      id_d    = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: take = found;
        BUSY: begin
          if (!req[id_q]) begin
            if (found) begin
              take = 1'b1;
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
              id_d    = 2'd0;
              cnt_d   = '0;
            end
          end else if (MAX_HOLD != 0 && cnt_q == CNT_SAT && found) begin
            take = 1'b1;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (take) begin
        state_d = BUSY;
        gnt_d   = 4'b0001 << win;
        id_d    = win;
        last_d  = win;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  // last_id resets to 3 so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign EOUT   = ~|gnt_q;

endmodule
